// File: rtl/resbus_pkg.sv
// Shared constants and state encoding for the result-bus arbiter.
package resbus_pkg;

    localparam int N_SRC_DEF = 11;
    localparam int SEL_W = 4;
    localparam logic [SEL_W-1:0] SEL_IDLE = '1;
    localparam int MAX_LOCK_DEF = 4;

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Circular priority encoder: lowest set request at or above ptr_i, else lowest overall.
module rr_pick #(
    parameter int N = 11,
    parameter int W = 4
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic         hit_o,
    output logic [W-1:0] idx_o
);

    // Descending scans let the lowest qualifying index win; the second scan
    // overrides with a hit at or above ptr, which is the circular order.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                hit_o = 1'b1;
                idx_o = W'(k);
            end
        end
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[k] && (W'(k) >= ptr_i)) begin
                idx_o = W'(k);
            end
        end
    end

endmodule

// File: rtl/resbus_arbiter.sv
// Round-robin arbiter/sequencer for the shared result bus, with capped bus lock.
// RESBUS_ARB_PRIO0_EN: source 0 wins every arbitration and never moves ptr or locks.
module resbus_arbiter #(
    parameter int N_SRC    = resbus_pkg::N_SRC_DEF,
    parameter int SEL_W    = resbus_pkg::SEL_W,
    parameter int MAX_LOCK = resbus_pkg::MAX_LOCK_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [N_SRC-1:0] req_i,
    input  logic [N_SRC-1:0] lock_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [SEL_W-1:0] sel_o,
    output logic [N_SRC-1:0] gnt_o
);
    import resbus_pkg::*;

    localparam int LCW = $clog2(MAX_LOCK + 1);
    localparam logic [SEL_W-1:0] IDLE_SEL = '1;
    localparam logic [SEL_W-1:0] LAST_SRC = SEL_W'(N_SRC - 1);
`ifdef RESBUS_ARB_PRIO0_EN
    localparam bit PRIO0 = 1'b1;
`else
    localparam bit PRIO0 = 1'b0;
`endif

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;

    logic [N_SRC-1:0] sel_oh, pick_req;
    logic [SEL_W-1:0] pick_ptr, pick_idx, arb_idx, ptr_adv;
    logic             pick_hit, arb_hit, xfer, lock_go, cur_prio;

    rr_pick #(.N(N_SRC), .W(SEL_W)) u_pick (
        .req_i (pick_req),
        .ptr_i (pick_ptr),
        .hit_o (pick_hit),
        .idx_o (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            sel_q      <= IDLE_SEL;
            ptr_q      <= '0;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            ptr_q      <= ptr_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    always_comb begin
        for (int k = 0; k < N_SRC; k++) begin
            sel_oh[k] = (sel_q == SEL_W'(k));
        end
        cur_prio = PRIO0 && sel_oh[0];
        xfer     = (state_q == ST_HOLD) && ready_i;
        lock_go  = xfer && |(lock_i & req_i & sel_oh) && !cur_prio &&
                   ((32'(lock_cnt_q) + 32'd1) < 32'(MAX_LOCK));
        ptr_adv  = (sel_q == LAST_SRC) ? '0 : sel_q + SEL_W'(1);

        // One encoder serves both IDLE arbitration and post-transfer re-arbitration.
        if (state_q == ST_IDLE) begin
            pick_req = req_i;
            pick_ptr = ptr_q;
        end else begin
            pick_req = req_i & ~sel_oh;
            pick_ptr = cur_prio ? ptr_q : ptr_adv;
        end

        arb_hit = pick_hit;
        arb_idx = pick_idx;
        if (PRIO0 && pick_req[0]) begin
            arb_hit = 1'b1;
            arb_idx = '0;
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_hit) begin
                    state_d    = ST_HOLD;
                    sel_d      = arb_idx;
                    lock_cnt_d = '0;
                end
            end
            ST_HOLD: begin
                if (lock_go) begin
                    lock_cnt_d = lock_cnt_q + LCW'(1);
                end else if (xfer) begin
                    ptr_d      = pick_ptr;
                    lock_cnt_d = '0;
                    if (arb_hit) begin
                        sel_d = arb_idx;
                    end else begin
                        state_d = ST_IDLE;
                        sel_d   = IDLE_SEL;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = IDLE_SEL;
            end
        endcase
    end

    // Grant is masked by reset so a transfer in the reset cycle is abandoned.
    always_comb begin
        valid_o = (state_q == ST_HOLD);
        sel_o   = sel_q;
        gnt_o   = (valid_o && ready_i && resetn) ? sel_oh : '0;
    end

endmodule

// File: tb/tb_resbus_arbiter.sv
// Scoreboard bench for resbus_arbiter: expected grant indices queued at stimulus, popped on gnt_o.
module tb_resbus_arbiter;
    localparam int N = 11;

    logic         clk = 1'b0;
    logic         resetn;
    logic [N-1:0] req_i, lock_i, gnt_o;
    logic         ready_i, valid_o;
    logic [3:0]   sel_o;

    logic [N-1:0] last_gnt = '0;
    logic [N-1:0] hold = '0;
    int           exp_q[$];
    int           n_chk = 0;
    int           n_bad = 0;

    resbus_arbiter dut (
        .clk     (clk),
        .resetn  (resetn),
        .req_i   (req_i),
        .lock_i  (lock_i),
        .ready_i (ready_i),
        .valid_o (valid_o),
        .sel_o   (sel_o),
        .gnt_o   (gnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] oh(input int i);
        return N'(1) << i;
    endfunction

    // Requesters drop a request the cycle after it is granted, unless held.
    task automatic tick;
        @(posedge clk);
        #1;
        req_i = (req_i & ~last_gnt) | hold;
    endtask

    task automatic do_rst;
        resetn = 1'b0;
        req_i  = '0;
        hold   = '0;
        lock_i = '0;
        tick;
        resetn = 1'b1;
    endtask

    always @(negedge clk) begin
        last_gnt <= gnt_o;
        if (gnt_o != '0) begin
            if (exp_q.size() == 0) chk("gnt_unexp", 32'(gnt_o), 32'd0);
            else chk("gnt", 32'(gnt_o), 32'(oh(exp_q.pop_front())));
        end
    end

    initial begin
        resetn  = 1'b0;
        req_i   = '0;
        lock_i  = '0;
        ready_i = 1'b0;
        tick;
        tick;
        @(negedge clk);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_sel", 32'(sel_o), 32'hF);
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        tick;
        resetn = 1'b1;

        // single request from source 0
        req_i = 11'h001; ready_i = 1'b1; exp_q.push_back(0);
        tick; @(negedge clk);
        chk("t1_valid", 32'(valid_o), 32'd1);
        chk("t1_sel", 32'(sel_o), 32'd0);
        tick; @(negedge clk);
        chk("t1_idle_valid", 32'(valid_o), 32'd0);
        chk("t1_idle_sel", 32'(sel_o), 32'hF);
        chk("t1_sb", 32'(exp_q.size()), 32'd0);

        // all sources, back-to-back rotation from ptr 0
        do_rst;
        hold = 11'h7FF; req_i = 11'h7FF;
        for (int i = 0; i < 12; i++) exp_q.push_back(i % N);
        repeat (12) tick;
        req_i = '0; hold = '0;
        tick; @(negedge clk);
        chk("t2_idle", 32'(valid_o), 32'd0);
        chk("t2_sb", 32'(exp_q.size()), 32'd0);

        // stall with ready low, ptr now 1
        req_i = 11'h00C; ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick; @(negedge clk);
            chk("t3_hold_sel", 32'(sel_o), 32'd2);
            chk("t3_hold_valid", 32'(valid_o), 32'd1);
        end
        exp_q.push_back(2); exp_q.push_back(3);
        tick; ready_i = 1'b1;
        @(negedge clk);
        chk("t3_gnt", 32'(gnt_o), 32'h004);
        tick; @(negedge clk);
        chk("t3_next_sel", 32'(sel_o), 32'd3);
        tick; @(negedge clk);
        chk("t3_idle", 32'(valid_o), 32'd0);
        chk("t3_sb", 32'(exp_q.size()), 32'd0);

        // lock capped at four beats, ptr now 4
        req_i = 11'h060; hold = 11'h020; lock_i = 11'h020;
        for (int i = 0; i < 4; i++) exp_q.push_back(5);
        exp_q.push_back(6);
        repeat (4) tick;
        hold = '0;
        @(negedge clk);
        chk("t4_sel5", 32'(sel_o), 32'd5);
        tick; @(negedge clk);
        chk("t4_sel6", 32'(sel_o), 32'd6);
        tick; lock_i = '0;
        @(negedge clk);
        chk("t4_idle", 32'(valid_o), 32'd0);
        chk("t4_sb", 32'(exp_q.size()), 32'd0);

        // reset mid-HOLD with ready high: transfer abandoned, ptr back to 0
        req_i = 11'h001; ready_i = 1'b0;
        tick;
        resetn = 1'b0; ready_i = 1'b1;
        @(negedge clk);
        chk("t5_gnt_in_rst", 32'(gnt_o), 32'd0);
        tick;
        resetn = 1'b1; req_i = 11'h401;
        exp_q.push_back(0); exp_q.push_back(10);
        @(negedge clk);
        chk("t5_rst_valid", 32'(valid_o), 32'd0);
        chk("t5_rst_sel", 32'(sel_o), 32'hF);
        repeat (3) tick;
        @(negedge clk);
        chk("t5_idle", 32'(valid_o), 32'd0);
        chk("t5_sb", 32'(exp_q.size()), 32'd0);

        // move ptr to 4, then sources 0 and 4 compete
        req_i = 11'h008; exp_q.push_back(3);
        tick; tick;
        req_i = 11'h011;
`ifdef RESBUS_ARB_PRIO0_EN
        exp_q.push_back(0); exp_q.push_back(4);
        tick; @(negedge clk); chk("t6_first", 32'(sel_o), 32'd0);
        tick; @(negedge clk); chk("t6_second", 32'(sel_o), 32'd4);
`else
        exp_q.push_back(4); exp_q.push_back(0);
        tick; @(negedge clk); chk("t6_first", 32'(sel_o), 32'd4);
        tick; @(negedge clk); chk("t6_second", 32'(sel_o), 32'd0);
`endif
        tick; @(negedge clk);
        chk("t6_idle", 32'(valid_o), 32'd0);
        chk("t6_sb", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/resbus_arbiter.md
# resbus_arbiter

Round-robin arbiter and sequencer for the shared 11-source result bus. It grants one of up to 11 requesting producers per transfer: ALU lanes, load unit, mul/div, CP0 and bypass sources. It drives the 4-bit select of the 11:1 result-bus multiplexer and a valid/ready handshake toward the writeback stage. It sits between the execute-stage producers and the writeback register, and owns all sequencing of the mux select.

## Interface
Parameters:
- N_SRC, 11, number of requesters (2..15).
- SEL_W, 4, select width; must satisfy 2^SEL_W > N_SRC.
- MAX_LOCK, 4, maximum consecutive transfers one locked source may take (≥1).

Ports:
- clk  in  1  single clock, rising edge.
- resetn  in  1  reset: synchronous, active-low.
- req_i  in  N_SRC  per-source request; once raised, held until that source's gnt_o.
- lock_i  in  N_SRC  source wants to keep the bus for its next beat; sampled at transfer.
- ready_i  in  1  writeback accepts the bus this cycle.
- valid_o  out  1  bus carries the selected source's data (registered).
- sel_o  out  SEL_W  mux select (registered); SEL_IDLE when not valid.
- gnt_o  out  N_SRC  one-hot transfer strobe; combinational; equals valid_o & ready_i decoded at sel_o.

## Operation
- Constant SEL_IDLE = all ones (4'hF); the mux outputs zero for any select above 10.
- State register:
  - IDLE: valid_o=0, sel_o=SEL_IDLE.
  - HOLD: valid_o=1, sel_o=winner, stable until transfer.
- Internal state: ptr (round-robin start, 0..N_SRC-1) and lock_cnt (0..MAX_LOCK).
- Pick function: the first set bit of a request vector, scanning circularly from ptr upward. Index N_SRC-1 wraps to 0.
- IDLE, any req_i set: sel_o←pick(req_i), valid_o←1, lock_cnt←0 → HOLD. No requests: stay IDLE.
- HOLD without ready_i: hold sel_o and valid_o. No re-arbitration; a new request never pre-empts the current winner.
- HOLD with ready_i: the transfer occurs and gnt_o[sel_o]=1 that cycle. Then:
  - Lock continue: when lock_i[sel_o] & req_i[sel_o] & (lock_cnt+1 < MAX_LOCK), stay HOLD on the same sel_o, lock_cnt+1, ptr unchanged.
  - Otherwise: ptr←(sel_o+1) mod N_SRC, lock_cnt←0.
  - Re-arbitrate on req_i with bit sel_o masked, using the new ptr. A hit loads the new sel_o and stays HOLD (back-to-back, no bubble). No hit → IDLE, sel_o←SEL_IDLE.
- Lock is always capped at MAX_LOCK consecutive beats per source, then forced rotation. This bounds starvation to (N_SRC-1)·MAX_LOCK transfers.
- req_i bits at indices ≥ N_SRC do not exist; sel_o never takes values N_SRC..SEL_IDLE-1.
- Withdrawing req_i before grant is a protocol violation. The arbiter keeps presenting the select and grants anyway.

## Timing
- Reset (resetn=0 at a rising edge): state IDLE, valid_o=0, sel_o=SEL_IDLE, ptr=0, lock_cnt=0. gnt_o=0 whenever resetn=0, including the cycle of a reset asserted mid-HOLD; that transfer is abandoned.
- Latency: req_i rise at cycle n → valid_o/sel_o at cycle n+1. Earliest gnt_o is cycle n+1 if ready_i is high.
- Throughput: one transfer per cycle while requests are pending and ready_i is high.
- Simultaneous events:
  - ready_i and a new request in the same cycle: the new request competes in the same-edge re-arbitration.
  - Transfer while all other requests are low and lock is denied: IDLE next cycle, even if the granted source raises a new request that cycle. It is seen in IDLE one cycle later.

## Configuration
- RESBUS_ARB_PRIO0_EN defined: source 0 (CP0/exception path) wins every arbitration (IDLE or re-arbitration) whenever req_i[0]=1, regardless of ptr.
  - It does not pre-empt HOLD.
  - Transfers from source 0 do not update ptr.
  - lock_i[0] is ignored.
- RESBUS_ARB_PRIO0_EN undefined: pure round-robin for all sources as above.

## Structure
- resbus_pkg: N_SRC default, SEL_W, SEL_IDLE, and the state enum (ST_IDLE, ST_HOLD).
- Sub-module rr_pick: a combinational circular priority encoder. Inputs are the request vector and ptr; outputs are a hit flag and the index. It is instantiated once in resbus_arbiter. The priority override sits outside it.

## Test plan
- Reset then req_i=11'h001 with ready_i=1: valid_o=1 and sel_o=0 next cycle, gnt_o=11'h001, then IDLE and sel_o=4'hF.
- req_i=11'h7FF held, ready_i=1, lock_i=0: grants in order 0,1,2,…,10,0, one per cycle, no bubbles.
- req_i=11'h00C, ready_i=0 for 5 cycles: sel_o=2 stable throughout. ready_i=1 → gnt_o=11'h004, next sel_o=3.
- Source 5 with req and lock held, source 6 requesting, MAX_LOCK=4: four consecutive grants to 5, then sel_o=6.
- resetn=0 during HOLD with ready_i=1: gnt_o=0 that cycle, then valid_o=0, sel_o=4'hF, ptr=0.
- With RESBUS_ARB_PRIO0_EN defined, ptr=4 and req_i=11'h011: sel_o=0 first, then 4. Without the macro: 4, then 0.
